// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// The arbiter merges the W-stage writeback with buffered MDU results.
package regfile_write_arbiter_pkg;

   localparam logic RegWEn_WRITE = 1'b1;
   localparam logic RegWEn_READ  = 1'b0;

   typedef enum logic [1:0] {
      ARB_SEL_NONE = 2'd0,
      ARB_SEL_WB   = 2'd1,
      ARB_SEL_MDU  = 2'd2
   } arbSel_e;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } mduEntry_t;

   localparam int MDU_ENTRY_W = $bits(mduEntry_t);

   // One-hot destination mask; x0 never maps to a bit.
   function automatic logic [31:0] rdMask(input logic [4:0] rd);
      logic [31:0] mask;
      mask = 32'd0;
      if (rd != 5'd0) begin
         mask[rd] = 1'b1;
      end else begin
         mask = 32'd0;
      end
      return mask;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_sync_fifo.sv
// Small synchronous FIFO holding MDU results until they win the write port.
// Pointers carry one wrap bit beyond the index so full/empty fall out of a compare.
module sync_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wrPtr_r;
   logic [AW:0]      rdPtr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];

   assign empty = (wrPtr_r == rdPtr_r);
   assign full  = (wrPtr_r[AW] != rdPtr_r[AW]) && (wrPtr_r[AW-1:0] == rdPtr_r[AW-1:0]);
   assign head  = mem_r[rdPtr_r[AW-1:0]];

   // Storage and pointer update; overflow/underflow requests are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_r <= {(AW+1){1'b0}};
         rdPtr_r <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (push && !full) begin
            mem_r[wrPtr_r[AW-1:0]] <= din;
            wrPtr_r <= wrPtr_r + PTR_ONE;
         end else begin
            wrPtr_r <= wrPtr_r;
         end
         if (pop && !empty) begin
            rdPtr_r <= rdPtr_r + PTR_ONE;
         end else begin
            rdPtr_r <= rdPtr_r;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the single register-file write port: W-stage writeback always wins,
// queued MDU results fill idle slots, and a pending scoreboard feeds decode hazards.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        mdu_valid,
   output logic        mdu_ready,
   input  logic [4:0]  mdu_rd,
   input  logic [31:0] mdu_data,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic        hazard,
   output logic        stall_req,
   output logic        rf_we,
   output logic [4:0]  rf_wa,
   output logic [31:0] rf_wd,
   output logic        err_waw
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
   localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};

   logic        wbAct_s;
   logic        fifoFull_s;
   logic        fifoEmpty_s;
   logic        push_s;
   logic        commit_s;
   mduEntry_t   pushEntry_s;
   mduEntry_t   head_s;
   arbSel_e     arbSel_s;
   logic [31:0] pending_r;
   logic [31:0] setMask_s;
   logic [31:0] clrMask_s;
   logic        wawIssue_s;
   logic        wawWb_s;
   logic [CW-1:0] starveCnt_r;
   logic        stall_r;
   logic        err_r;

   assign wbAct_s     = wb_we && (wb_rd != 5'd0);
   assign push_s      = mdu_valid && !fifoFull_s && (mdu_rd != 5'd0);
   assign pushEntry_s = '{rd: mdu_rd, data: mdu_data};
   assign mdu_ready   = !fifoFull_s;
   assign commit_s    = (arbSel_s == ARB_SEL_MDU);

   sync_fifo #(
      .WIDTH (MDU_ENTRY_W),
      .DEPTH (DEPTH)
   ) u_mduFifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (commit_s),
      .din   (pushEntry_s),
      .full  (fifoFull_s),
      .empty (fifoEmpty_s),
      .head  (head_s)
   );

   // Write-port arbitration; the port is held idle while reset is asserted.
   always_comb begin
      arbSel_s = ARB_SEL_NONE;
      if (!rst_n) begin
         arbSel_s = ARB_SEL_NONE;
      end else if (wbAct_s) begin
         arbSel_s = ARB_SEL_WB;
      end else if (!fifoEmpty_s) begin
         arbSel_s = ARB_SEL_MDU;
      end else begin
         arbSel_s = ARB_SEL_NONE;
      end
      case (arbSel_s)
         ARB_SEL_WB: begin
            rf_we = RegWEn_WRITE;
            rf_wa = wb_rd;
            rf_wd = wb_data;
         end
         ARB_SEL_MDU: begin
            rf_we = RegWEn_WRITE;
            rf_wa = head_s.rd;
            rf_wd = head_s.data;
         end
         default: begin
            rf_we = RegWEn_READ;
            rf_wa = 5'd0;
            rf_wd = 32'd0;
         end
      endcase
   end

   // Scoreboard set/clear masks and WAW protocol checks.
   always_comb begin
      if (issue_valid) begin
         setMask_s = rdMask(issue_rd);
      end else begin
         setMask_s = 32'd0;
      end
      if (commit_s) begin
         clrMask_s = rdMask(head_s.rd);
      end else begin
         clrMask_s = 32'd0;
      end
      wawIssue_s = issue_valid && (issue_rd != 5'd0) && pending_r[issue_rd] && !clrMask_s[issue_rd];
      wawWb_s    = wbAct_s && pending_r[wb_rd];
   end

   assign hazard = pending_r[rs1] | pending_r[rs2];

   // Pending-destination scoreboard; a same-cycle set overrides the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r <= 32'd0;
      end else begin
         pending_r <= (pending_r & ~clrMask_s) | setMask_s;
      end
   end

   // Sticky protocol-violation flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if (wawIssue_s || wawWb_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   // Starvation counter for the FIFO head; stall request held until it commits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starveCnt_r <= {CW{1'b0}};
         stall_r     <= 1'b0;
      end else if (fifoEmpty_s || commit_s) begin
         starveCnt_r <= {CW{1'b0}};
         stall_r     <= 1'b0;
      end else if (starveCnt_r < STARVE_LIM) begin
         starveCnt_r <= starveCnt_r + CNT_ONE;
         stall_r     <= ((starveCnt_r + CNT_ONE) == STARVE_LIM);
      end else begin
         starveCnt_r <= starveCnt_r;
         stall_r     <= 1'b1;
      end
   end

   assign stall_req = stall_r;
   assign err_waw   = err_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: accepted MDU results go into an expected queue and are
// popped as the write port should commit them; side outputs are checked directly.
module tb_regfile_write_arbiter;

   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        hazard;
   logic        stall_req;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic        err_waw;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } expEnt_t;

   expEnt_t expQ[$];
   int testsRun    = 0;
   int testsFailed = 0;

   regfile_write_arbiter #(
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .mdu_valid   (mdu_valid),
      .mdu_ready   (mdu_ready),
      .mdu_rd      (mdu_rd),
      .mdu_data    (mdu_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .hazard      (hazard),
      .stall_req   (stall_req),
      .rf_we       (rf_we),
      .rf_wa       (rf_wa),
      .rf_wd       (rf_wd),
      .err_waw     (err_waw)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded its time budget");
      $fatal(1, "watchdog");
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
      mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
      issue_valid = 1'b0; issue_rd = 5'd0;
      rs1 = 5'd0; rs2 = 5'd0;
   endtask

   // One clock: check the write port against the scoreboard, then update it.
   task automatic tick();
      logic    expWe;
      logic [4:0]  expWa;
      logic [31:0] expWd;
      logic    popNow;
      logic    pushNow;
      expEnt_t newEnt;
      @(negedge clk);
      popNow = 1'b0; expWe = 1'b0; expWa = 5'd0; expWd = 32'd0;
      if (wb_we && wb_rd != 5'd0) begin
         expWe = 1'b1; expWa = wb_rd; expWd = wb_data;
      end else if (expQ.size() > 0) begin
         expWe = 1'b1; expWa = expQ[0].rd; expWd = expQ[0].data; popNow = 1'b1;
      end
      checkVal("rf_we", 32'(rf_we), 32'(expWe));
      checkVal("rf_wa", 32'(rf_wa), 32'(expWa));
      checkVal("rf_wd", rf_wd, expWd);
      checkVal("mdu_ready", 32'(mdu_ready), 32'(expQ.size() < DEPTH));
      pushNow = mdu_valid && (expQ.size() < DEPTH) && (mdu_rd != 5'd0);
      newEnt.rd = mdu_rd;
      newEnt.data = mdu_data;
      @(posedge clk);
      #1;
      if (popNow) expQ.delete(0);
      if (pushNow) expQ.push_back(newEnt);
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      checkVal("reset_rf_we", 32'(rf_we), 32'd0);
      rst_n = 1'b1;
      rs1 = 5'd5;
      #1;
      checkVal("reset_ready", 32'(mdu_ready), 32'd1);
      checkVal("reset_hazard", 32'(hazard), 32'd0);
      checkVal("reset_stall", 32'(stall_req), 32'd0);
      checkVal("reset_err", 32'(err_waw), 32'd0);

      // Reset mid-operation with two queued entries and x5 pending
      idle();
      wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'h0000_1010;
      issue_valid = 1'b1; issue_rd = 5'd5;
      mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_data = 32'h0000_2020;
      tick();
      issue_valid = 1'b0;
      mdu_rd = 5'd21; mdu_data = 32'h0000_2121;
      tick();
      mdu_valid = 1'b0; rs1 = 5'd5;
      #1;
      checkVal("t1_hazard_pre", 32'(hazard), 32'd1);
      checkVal("t1_full", 32'(mdu_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      checkVal("t1_rst_rf_we", 32'(rf_we), 32'd0);
      expQ.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checkVal("t1_ready", 32'(mdu_ready), 32'd1);
      checkVal("t1_hazard", 32'(hazard), 32'd0);
      checkVal("t1_err", 32'(err_waw), 32'd0);
      checkVal("t1_stall", 32'(stall_req), 32'd0);
      idle();
      tick();

      // Idle W: result commits one cycle after acceptance
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick();
      issue_valid = 1'b0; rs1 = 5'd7;
      #1;
      checkVal("t2_hazard_issued", 32'(hazard), 32'd1);
      mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'hDEAD_BEEF;
      tick();
      mdu_valid = 1'b0;
      #1;
      checkVal("t2_hazard_queued", 32'(hazard), 32'd1);
      tick();
      checkVal("t2_hazard_after", 32'(hazard), 32'd0);
      checkVal("t2_err", 32'(err_waw), 32'd0);

      // Contention: queued rd=3 starves behind W writes to x9
      idle();
      wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0909;
      mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'h0000_0333;
      tick();
      mdu_valid = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i == 3) checkVal("t3_stall_3", 32'(stall_req), 32'd0);
         if (i == 4) checkVal("t3_stall_4", 32'(stall_req), 32'd1);
         if (i == 5) checkVal("t3_stall_held", 32'(stall_req), 32'd1);
      end
      wb_we = 1'b0;
      tick();
      checkVal("t3_stall_clear", 32'(stall_req), 32'd0);

      // Full FIFO refuses a third result; order preserved on drain
      idle();
      wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'h0000_0A0A;
      mdu_valid = 1'b1; mdu_rd = 5'd11; mdu_data = 32'hAAAA_0011;
      tick();
      mdu_rd = 5'd12; mdu_data = 32'hBBBB_0012;
      tick();
      checkVal("t4_full", 32'(mdu_ready), 32'd0);
      mdu_rd = 5'd13; mdu_data = 32'hCCCC_0013;
      tick();
      mdu_valid = 1'b0; wb_we = 1'b0;
      tick();
      checkVal("t4_ready_after_pop", 32'(mdu_ready), 32'd1);
      tick();
      tick();

      // x0 handling on both writers and on issue
      idle();
      wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'h0000_0A0A;
      mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'h4444_0004;
      tick();
      mdu_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0000_BAD0;
      tick();
      wb_we = 1'b0;
      mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'h0000_0BAD;
      tick();
      mdu_valid = 1'b0;
      tick();
      issue_valid = 1'b1; issue_rd = 5'd0;
      tick();
      issue_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
      #1;
      checkVal("t5_hazard_x0", 32'(hazard), 32'd0);
      checkVal("t5_err", 32'(err_waw), 32'd0);

      // Same-cycle commit and reissue of x8, then a true WAW
      idle();
      issue_valid = 1'b1; issue_rd = 5'd8;
      tick();
      issue_valid = 1'b0;
      mdu_valid = 1'b1; mdu_rd = 5'd8; mdu_data = 32'h8888_0008;
      tick();
      mdu_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd8;
      tick();
      issue_valid = 1'b0; rs2 = 5'd8;
      #1;
      checkVal("t6_pending_kept", 32'(hazard), 32'd1);
      checkVal("t6_err_clean", 32'(err_waw), 32'd0);
      issue_valid = 1'b1; issue_rd = 5'd8;
      tick();
      issue_valid = 1'b0;
      checkVal("t6_err_set", 32'(err_waw), 32'd1);
      tick();
      tick();
      checkVal("t6_err_sticky", 32'(err_waw), 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Owns the single register-file write port. Merges two writers: the W-stage writeback (gated by the W-stage RegWEn decode), which never stalls, and a multi-cycle unit (MDU: mul/div) whose results are buffered in a small FIFO. Also keeps a pending-destination scoreboard so decode can stall on RAW/WAW hazards against in-flight MDU results.

Parameters:
DEPTH, 2, MDU result FIFO entries (power of 2, >=2)
STARVE_MAX, 4, consecutive cycles a queued MDU result may lose arbitration before stall_req asserts (>=1)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
wb_we  in  1  W-stage write enable (RegWEn output)
wb_rd  in  5  W-stage destination register
wb_data  in  32  W-stage write data
mdu_valid  in  1  MDU result valid
mdu_ready  out  1  FIFO can accept (= !full)
mdu_rd  in  5  MDU result destination
mdu_data  in  32  MDU result data
issue_valid  in  1  MDU op issued this cycle
issue_rd  in  5  destination of issued MDU op
rs1  in  5  decode source 1 query
rs2  in  5  decode source 2 query
hazard  out  1  rs1 or rs2 (nonzero) is pending
stall_req  out  1  request front-end bubble so W slot frees
rf_we  out  1  register-file write enable
rf_wa  out  5  register-file write address
rf_wd  out  32  register-file write data
err_waw  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst_n low, async): FIFO empty, scoreboard all 0, starvation counter 0, stall_req 0, err_waw 0. rf_we forced 0 while rst_n low, regardless of wb_we.
- W wins when wb_act = wb_we && wb_rd!=0: rf_we=1, rf_wa=wb_rd, rf_wd=wb_data (combinational, same cycle).
- Else, if FIFO non-empty: rf_* = FIFO head, rf_we=1, head popped at clock edge (commit).
- Else rf_we=0, rf_wa=0, rf_wd=0.
- Writes to x0 never reach the port. wb_rd=0 counts as no W write. MDU entries with rd=0 are dropped at push.
- Push on mdu_valid && mdu_ready. No bypass: an MDU result commits no earlier than the cycle after it is accepted.
- mdu_ready = !full. It depends only on state, not on same-cycle pop. Full with simultaneous pop still refuses.
- Pointers are log2(DEPTH) bits plus a wrap bit. Full/empty come from pointer compare, wrapping modulo DEPTH.
- Scoreboard pending[31:1], pending[0] hardwired 0:
  - Set at edge when issue_valid && issue_rd!=0.
  - Cleared at edge when an MDU entry with that rd commits.
  - Same-cycle set and clear of the same rd: set wins.
- hazard = pending[rs1] | pending[rs2], combinational.
- err_waw sets (sticky until reset) when either:
  - issue_valid targets an rd that is already pending and not being cleared that cycle, or
  - wb_act writes an rd that is pending.
  - Arbitration is unaffected by err_waw.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head does not commit (wb_act won). Saturates at STARVE_MAX.
  - Clears on head commit or when the FIFO is empty.
  - stall_req is registered: 1 at the edge where the counter reaches STARVE_MAX, held until the head commits.
  - stall_req does not itself block wb_act; the front-end guarantees a bubble reaches W.
- Simultaneous push and pop with FIFO non-empty: both occur, occupancy unchanged. Pushing into an empty FIFO while W is idle: the entry commits next cycle.

Decomposition:
- Shared package/header (alongside ControlLogicSel.vh): RegWEn_WRITE/RegWEn_READ reused for rf_we; add ARB_SEL_WB/ARB_SEL_MDU select constants.
- One sub-module, sync_fifo (parameterised width=37, DEPTH, outputs full/empty/head). Scoreboard, starvation counter and mux stay in the top level.

Test Plan:
1. Reset mid-operation: FIFO holding 2 entries, pending[5]=1, drop rst_n -> immediately rf_we=0; after release mdu_ready=1, hazard=0 for rs1=5, err_waw=0.
2. Idle W: issue rd=7, one cycle later mdu_valid rd=7 data=0xDEADBEEF -> rf_we=1, rf_wa=7, rf_wd=0xDEADBEEF exactly one cycle after acceptance; hazard(rs1=7) is 1 from the cycle after issue until the cycle after commit.
3. Contention: FIFO head rd=3, wb_we=1 rd=9 for 6 cycles, STARVE_MAX=4 -> rf_wa=9 each cycle; stall_req rises after the 4th losing cycle; wb_we drops -> rd=3 commits, stall_req 0 next cycle.
4. Full: DEPTH=2, W busy, push 2 results -> mdu_ready=0; third mdu_valid is not accepted; one pop -> mdu_ready=1 next cycle; order preserved (FIFO).
5. x0 handling: wb_we=1 wb_rd=0 with FIFO head rd=4 -> rd=4 commits that cycle; mdu_valid rd=0 -> no push, no rf_we; issue_rd=0 -> hazard(rs1=0)=0.
6. Protocol violation: pending[8]=1, issue_valid rd=8 -> err_waw=1 next cycle and stays 1; same-cycle commit of rd=8 plus issue rd=8 -> pending[8] stays 1, err_waw stays 0.
